// File: rtl/boot_seq_monitor.sv
// Boot-sequence checker: snoops the IRAM copy and the first jump to the application,
// flags pass/fail with the first failure cause.
module boot_seq_monitor #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                NUM_WORDS      = 4,
   parameter logic [ADDR_W-1:0] APP_BASE       = 32'h0010_0000,
   parameter int                TIMEOUT_CYCLES = 50000,
   parameter int                CHECK_SUM      = 1,
   parameter logic [DATA_W-1:0] EXP_SUM        = 32'h1B55_2D5C,
   localparam int               CW             = $clog2(NUM_WORDS+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iram_wvalid,
   input  logic              iram_wready,
   input  logic [ADDR_W-1:0] iram_waddr,
   input  logic [DATA_W-1:0] iram_wdata,
   input  logic              fetch_valid,
   input  logic              fetch_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [CW-1:0]     word_cnt,
   output logic [DATA_W-1:0] checksum,
   output logic              boot_done,
   output logic              boot_fail,
   output logic [2:0]        fail_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   typedef enum logic [1:0] {COPY, WAIT_JUMP, DONE, FAIL} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt_nxt;
   logic [DATA_W-1:0] sum_nxt, sum_add;
   logic [2:0]        code_nxt;
   logic [TW-1:0]     cyc, cyc_nxt;
   logic [ADDR_W-1:0] exp_addr;
   logic              wr, jmp, last, tmo;

   assign wr       = iram_wvalid & iram_wready;
   assign jmp      = fetch_valid & fetch_ready & (fetch_addr == APP_BASE);
   assign exp_addr = APP_BASE + (ADDR_W'(word_cnt) << 2);
   assign last     = (word_cnt == CW'(NUM_WORDS-1));
   assign sum_add  = checksum + iram_wdata;
   // The counter parks at the last budget cycle, so any idle cycle from there on times out.
   assign tmo      = (cyc == TW'(TIMEOUT_CYCLES-1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = word_cnt;
      sum_nxt   = checksum;
      code_nxt  = fail_code;
      cyc_nxt   = cyc;
      case (state)
         COPY: begin
            if (!tmo) cyc_nxt = cyc + 1'b1;
            if (wr) begin
               if (iram_waddr == exp_addr) begin
                  cnt_nxt = word_cnt + 1'b1;
                  sum_nxt = sum_add;
                  if (last) begin
                     if (CHECK_SUM != 0 && sum_add != EXP_SUM) begin
                        state_nxt = FAIL;
                        code_nxt  = 3'd4;
                     end else begin
                        state_nxt = WAIT_JUMP;
                     end
                  end
               end else begin
                  state_nxt = FAIL;
                  code_nxt  = 3'd2;
               end
            end else if (jmp) begin
               state_nxt = FAIL;
               code_nxt  = 3'd3;
            end else if (tmo) begin
               state_nxt = FAIL;
               code_nxt  = 3'd1;
            end
         end
         WAIT_JUMP: begin
            if (!tmo) cyc_nxt = cyc + 1'b1;
            if (wr) begin
               state_nxt = FAIL;
               code_nxt  = 3'd5;
            end else if (jmp) begin
               state_nxt = DONE;
            end else if (tmo) begin
               state_nxt = FAIL;
               code_nxt  = 3'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COPY;
         word_cnt  <= '0;
         checksum  <= '0;
         fail_code <= '0;
         cyc       <= '0;
      end else begin
         state     <= state_nxt;
         word_cnt  <= cnt_nxt;
         checksum  <= sum_nxt;
         fail_code <= code_nxt;
         cyc       <= cyc_nxt;
      end
   end

   assign boot_done = (state == DONE);
   assign boot_fail = (state == FAIL);

endmodule
